// File: rtl/regfile_pkg.sv
// Shared widths and port-packing helpers for the RV64IF integer and FP register files.
package regfile_pkg;

  localparam int XLEN = 64;
  localparam int FLEN = 64;

  localparam int DEFAULT_DATA_WIDTH = XLEN;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_WRITE  = 2;
  localparam int INT_NUM_READ       = 2;
  localparam int FP_NUM_READ        = 3;

  // Low bit of port p's field inside a flat packed port bus.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection, plus the sticky write-after-write error flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_WRITE  = DEFAULT_NUM_WRITE,
  parameter int ZERO_REG   = 1
) (
  input  logic                          in_Clk,
  input  logic                          in_Rst_N,
  input  logic [NUM_WRITE-1:0]          wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_addr,
  input  logic                          flush,
  output logic [2**ADDR_WIDTH-1:0]      busy,
  output logic                          last_issue_en,
  output logic [ADDR_WIDTH-1:0]         last_issue_addr,
  output logic                          waw_err
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic             issue_ok;
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] busy_next;
  logic             waw_set;

  assign issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en[w]) begin
        wr_hit[wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  // Priority low to high: write clears, issue sets (new producer), flush clears all.
  always_comb begin
    busy_next = busy & ~wr_hit;
    if (issue_ok) begin
      busy_next[issue_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  assign waw_set = issue_ok && busy[issue_addr] && !wr_hit[issue_addr];

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      busy            <= '0;
      last_issue_en   <= 1'b0;
      last_issue_addr <= '0;
      waw_err         <= 1'b0;
    end else begin
      busy            <= busy_next;
      last_issue_en   <= issue_ok;
      last_issue_addr <= issue_addr;
      if (waw_set) begin
        waw_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and an integrated scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = FP_NUM_READ,
  parameter int NUM_WRITE  = DEFAULT_NUM_WRITE,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           in_Clk,
  input  logic                           in_Rst_N,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] in_rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] out_rd_data,
  output logic [NUM_READ-1:0]            out_rd_busy,
  input  logic [NUM_WRITE-1:0]           in_wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] in_wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] in_wr_data,
  input  logic                           in_issue_en,
  input  logic [ADDR_WIDTH-1:0]          in_issue_addr,
  input  logic                           in_flush,
  output logic                           out_waw_err
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  last_issue_en;
  logic [ADDR_WIDTH-1:0] last_issue_addr;

  // Ascending port order makes the highest-index port win a same-address collision.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (in_wr_en[w] &&
            !((ZERO_REG != 0) && (in_wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH] == '0))) begin
          regs[in_wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH]] <=
            in_wr_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .in_Clk          (in_Clk),
    .in_Rst_N        (in_Rst_N),
    .wr_en           (in_wr_en),
    .wr_addr         (in_wr_addr),
    .issue_en        (in_issue_en),
    .issue_addr      (in_issue_addr),
    .flush           (in_flush),
    .busy            (busy),
    .last_issue_en   (last_issue_en),
    .last_issue_addr (last_issue_addr),
    .waw_err         (out_waw_err)
  );

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  wr_match;

    assign addr = in_rd_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];

    // Later write ports override earlier ones so the bypass agrees with what gets stored.
    always_comb begin
      data     = regs[addr];
      wr_match = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (in_wr_en[w] && (in_wr_addr[slice_lo(w, ADDR_WIDTH) +: ADDR_WIDTH] == addr)) begin
            data     = in_wr_data[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
            wr_match = 1'b1;
          end
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data     = '0;
        wr_match = 1'b0;
      end
      if (!in_Rst_N) begin
        data = '0;
      end
    end

    assign out_rd_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = data;

    // A same-cycle write hides busy unless an issue to this register landed last cycle.
    assign out_rd_busy[p] = busy[addr] &&
                            !(wr_match && !(last_issue_en && (last_issue_addr == addr)));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: integer, FP and no-bypass instances share stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  logic             in_Clk   = 1'b0;
  logic             in_Rst_N = 1'b0;
  logic [3*AW-1:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*DW-1:0]  wr_data;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             flush;

  logic [2*DW-1:0]  int_data;
  logic [1:0]       int_busy;
  logic             int_waw;
  logic [3*DW-1:0]  fp_data;
  logic [2:0]       fp_busy;
  logic             fp_waw;
  logic [2*DW-1:0]  nb_data;
  logic [1:0]       nb_busy;
  logic             nb_waw;

  int checks = 0;
  int errors = 0;

  always #5 in_Clk = ~in_Clk;

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .NUM_WRITE(2),
               .ZERO_REG(1), .BYPASS(1)) u_int (
    .in_Clk(in_Clk), .in_Rst_N(in_Rst_N),
    .in_rd_addr(rd_addr[2*AW-1:0]), .out_rd_data(int_data), .out_rd_busy(int_busy),
    .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
    .in_issue_en(issue_en), .in_issue_addr(issue_addr), .in_flush(flush),
    .out_waw_err(int_waw)
  );

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(3), .NUM_WRITE(2),
               .ZERO_REG(0), .BYPASS(1)) u_fp (
    .in_Clk(in_Clk), .in_Rst_N(in_Rst_N),
    .in_rd_addr(rd_addr), .out_rd_data(fp_data), .out_rd_busy(fp_busy),
    .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
    .in_issue_en(issue_en), .in_issue_addr(issue_addr), .in_flush(flush),
    .out_waw_err(fp_waw)
  );

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .NUM_WRITE(2),
               .ZERO_REG(1), .BYPASS(0)) u_nb (
    .in_Clk(in_Clk), .in_Rst_N(in_Rst_N),
    .in_rd_addr(rd_addr[2*AW-1:0]), .out_rd_data(nb_data), .out_rd_busy(nb_busy),
    .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
    .in_issue_en(issue_en), .in_issue_addr(issue_addr), .in_flush(flush),
    .out_waw_err(nb_waw)
  );

  task idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    flush      = 1'b0;
  endtask

  task set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task do_write(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[port]          = 1'b1;
    wr_addr[port*AW +: AW] = a;
    wr_data[port*DW +: DW] = d;
  endtask

  task do_issue(input logic [AW-1:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  task test_reset();
    idle();
    rd_addr  = '0;
    in_Rst_N = 1'b0;
    @(negedge in_Clk);
    in_Rst_N = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge in_Clk);
      set_rd(0, AW'(a)); set_rd(1, AW'(a)); set_rd(2, AW'(a));
      #1;
      checks++;
      if (int_data[DW-1:0] !== 64'h0) begin
        errors++; $display("[TB] FAIL reset_int_data addr %0d: got %h expected 0", a, int_data[DW-1:0]);
      end
      checks++;
      if (fp_data[2*DW +: DW] !== 64'h0) begin
        errors++; $display("[TB] FAIL reset_fp_data addr %0d: got %h expected 0", a, fp_data[2*DW +: DW]);
      end
      checks++;
      if (int_busy !== 2'b00 || fp_busy !== 3'b000) begin
        errors++; $display("[TB] FAIL reset_busy addr %0d: got int %b fp %b expected 0", a, int_busy, fp_busy);
      end
    end
    @(negedge in_Clk);
    do_write(0, 5'd5, 64'hDEAD);
    set_rd(0, 5'd5);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'hDEAD) begin
      errors++; $display("[TB] FAIL pre_reset_x5: got %h expected dead", int_data[DW-1:0]);
    end
    in_Rst_N = 1'b0;
    do_write(0, 5'd5, 64'hBEEF);
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'h0) begin
      errors++; $display("[TB] FAIL during_reset_x5: got %h expected 0", int_data[DW-1:0]);
    end
    @(negedge in_Clk);
    idle();
    in_Rst_N = 1'b1;
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'h0 || fp_data[DW-1:0] !== 64'h0) begin
      errors++; $display("[TB] FAIL after_reset_x5: got int %h fp %h expected 0", int_data[DW-1:0], fp_data[DW-1:0]);
    end
  endtask

  task test_zero_reg();
    @(negedge in_Clk);
    idle();
    do_write(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_rd(0, 5'd0);
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'h0) begin
      errors++; $display("[TB] FAIL zero_bypass_int: got %h expected 0", int_data[DW-1:0]);
    end
    checks++;
    if (fp_data[DW-1:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL zero_bypass_fp: got %h expected ffffffffffffffff", fp_data[DW-1:0]);
    end
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'h0 || nb_data[DW-1:0] !== 64'h0) begin
      errors++; $display("[TB] FAIL zero_stored_int: got int %h nb %h expected 0", int_data[DW-1:0], nb_data[DW-1:0]);
    end
    checks++;
    if (fp_data[DW-1:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL zero_stored_fp: got %h expected ffffffffffffffff", fp_data[DW-1:0]);
    end
    do_issue(5'd0);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_issue_int_busy: got %b expected 0", int_busy[0]);
    end
    checks++;
    if (fp_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_issue_fp_busy: got %b expected 1", fp_busy[0]);
    end
    flush = 1'b1;
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (fp_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_flush_fp_busy: got %b expected 0", fp_busy[0]);
    end
  endtask

  task test_collision();
    @(negedge in_Clk);
    idle();
    do_write(0, 5'd7, 64'h33);
    set_rd(0, 5'd7);
    @(negedge in_Clk);
    idle();
    do_write(0, 5'd7, 64'h11);
    do_write(1, 5'd7, 64'h22);
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'h22 || fp_data[DW-1:0] !== 64'h22) begin
      errors++; $display("[TB] FAIL collision_bypass: got int %h fp %h expected 22", int_data[DW-1:0], fp_data[DW-1:0]);
    end
    checks++;
    if (nb_data[DW-1:0] !== 64'h33) begin
      errors++; $display("[TB] FAIL collision_nobypass: got %h expected 33", nb_data[DW-1:0]);
    end
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_data[DW-1:0] !== 64'h22 || fp_data[DW-1:0] !== 64'h22 || nb_data[DW-1:0] !== 64'h22) begin
      errors++; $display("[TB] FAIL collision_stored: got int %h fp %h nb %h expected 22",
                         int_data[DW-1:0], fp_data[DW-1:0], nb_data[DW-1:0]);
    end
  endtask

  task test_busy();
    @(negedge in_Clk);
    idle();
    set_rd(0, 5'd9);
    do_issue(5'd9);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_busy[0] !== 1'b1 || fp_busy[0] !== 1'b1 || nb_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_after_issue: got int %b fp %b nb %b expected 1", int_busy[0], fp_busy[0], nb_busy[0]);
    end
    @(negedge in_Clk);
    do_write(0, 5'd9, 64'h5);
    #1;
    checks++;
    if (int_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_bypass_clear: got %b expected 0", int_busy[0]);
    end
    checks++;
    if (nb_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_nobypass_write_cycle: got %b expected 1", nb_busy[0]);
    end
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_busy[0] !== 1'b0 || nb_busy[0] !== 1'b0 || int_data[DW-1:0] !== 64'h5) begin
      errors++; $display("[TB] FAIL busy_cleared: got int %b nb %b data %h expected 0 0 5", int_busy[0], nb_busy[0], int_data[DW-1:0]);
    end
    do_issue(5'd9);
    do_write(0, 5'd9, 64'h6);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_busy[0] !== 1'b1 || nb_busy[0] !== 1'b1 || int_data[DW-1:0] !== 64'h6) begin
      errors++; $display("[TB] FAIL busy_issue_and_write: got int %b nb %b data %h expected 1 1 6", int_busy[0], nb_busy[0], int_data[DW-1:0]);
    end
    do_write(0, 5'd9, 64'h7);
    #1;
    checks++;
    if (int_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_recent_issue_bypass: got %b expected 1", int_busy[0]);
    end
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_busy[0] !== 1'b0 || nb_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_final_clear: got int %b nb %b expected 0", int_busy[0], nb_busy[0]);
    end
  endtask

  task test_flush();
    @(negedge in_Clk); idle(); do_issue(5'd1);
    @(negedge in_Clk); idle(); do_issue(5'd2);
    @(negedge in_Clk); idle(); do_issue(5'd31);
    @(negedge in_Clk);
    idle();
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd31);
    #1;
    checks++;
    if (fp_busy !== 3'b111) begin
      errors++; $display("[TB] FAIL flush_setup_busy: got %b expected 111", fp_busy);
    end
    flush = 1'b1;
    do_issue(5'd4);
    do_write(0, 5'd10, 64'hABC);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (fp_busy !== 3'b000 || int_busy !== 2'b00) begin
      errors++; $display("[TB] FAIL flush_cleared: got fp %b int %b expected 0", fp_busy, int_busy);
    end
    set_rd(0, 5'd4); set_rd(1, 5'd10);
    #1;
    checks++;
    if (int_busy[0] !== 1'b0 || fp_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_overrides_issue: got int %b fp %b expected 0", int_busy[0], fp_busy[0]);
    end
    checks++;
    if (int_data[DW +: DW] !== 64'hABC || fp_data[DW +: DW] !== 64'hABC) begin
      errors++; $display("[TB] FAIL flush_write_kept: got int %h fp %h expected abc", int_data[DW +: DW], fp_data[DW +: DW]);
    end
  endtask

  task test_waw();
    @(negedge in_Clk);
    idle();
    set_rd(0, 5'd3);
    do_issue(5'd3);
    @(negedge in_Clk);
    idle();
    do_issue(5'd3);
    do_write(0, 5'd3, 64'h1);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_waw !== 1'b0 || fp_waw !== 1'b0) begin
      errors++; $display("[TB] FAIL waw_cleared_by_write: got int %b fp %b expected 0", int_waw, fp_waw);
    end
    checks++;
    if (int_busy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL waw_reissue_busy: got %b expected 1", int_busy[0]);
    end
    do_issue(5'd3);
    @(negedge in_Clk);
    idle();
    #1;
    checks++;
    if (int_waw !== 1'b1 || fp_waw !== 1'b1 || nb_waw !== 1'b1) begin
      errors++; $display("[TB] FAIL waw_set: got int %b fp %b nb %b expected 1", int_waw, fp_waw, nb_waw);
    end
    do_write(0, 5'd3, 64'h2);
    @(negedge in_Clk);
    idle();
    @(negedge in_Clk);
    #1;
    checks++;
    if (int_waw !== 1'b1 || int_busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL waw_sticky: got waw %b busy %b expected 1 0", int_waw, int_busy[0]);
    end
    in_Rst_N = 1'b0;
    #1;
    checks++;
    if (int_waw !== 1'b0 || fp_waw !== 1'b0) begin
      errors++; $display("[TB] FAIL waw_reset: got int %b fp %b expected 0", int_waw, fp_waw);
    end
    @(negedge in_Clk);
    in_Rst_N = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting regfile_mp bench");
    test_reset();
    test_zero_reg();
    test_collision();
    test_busy();
    test_flush();
    test_waw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with integrated scoreboard for the RV64IF core, serving both the integer (x0 hardwired to zero) and floating-point (f0 writable) register sets. It provides NUM_READ combinational read ports, enough for the rs3 operand of fused multiply-add, and NUM_WRITE clocked write ports for the ALU/FPU and load writeback. It also provides optional write-to-read bypass and per-register busy bits that the issue stage uses for hazard detection.

## Interface
- DATA_WIDTH, 64, register width
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- NUM_READ, 3, read ports
- NUM_WRITE, 2, write ports
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy; 0: register 0 is ordinary
- BYPASS, 1, 1: a read of an address written this cycle returns the write data
- in_Clk  in  1  clock, rising edge
- in_Rst_N  in  1  reset, asynchronous, active-low
- in_rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- out_rd_data  out  NUM_READ*DATA_WIDTH  read data, same packing
- out_rd_busy  out  NUM_READ  busy bit of each read address
- in_wr_en  in  NUM_WRITE  write enables
- in_wr_addr  in  NUM_WRITE*ADDR_WIDTH  write addresses
- in_wr_data  in  NUM_WRITE*DATA_WIDTH  write data
- in_issue_en  in  1  marks in_issue_addr as pending (destination of an issued instruction)
- in_issue_addr  in  ADDR_WIDTH  destination being issued
- in_flush  in  1  clears all busy bits (pipeline flush)
- out_waw_err  out  1  sticky; set when issue targets an already-busy register

## Operation
- Reset: all registers 0, all busy bits 0, out_waw_err 0. As a result, out_rd_data = 0 and out_rd_busy = 0 during reset.
- Read: combinational. With ZERO_REG=1, address 0 returns all zeros.
- Bypass (BYPASS=1): if in_wr_en[w] and in_wr_addr[w] match a read address, that read returns in_wr_data[w] in the same cycle. The highest-index matching w wins. Address 0 is never bypassed when ZERO_REG=1. With BYPASS=0, reads return the stored value.
- Write: on the rising edge, each enabled port writes its address.
  - Same-address collision: the highest-index port wins, and the others are discarded.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Scoreboard: one busy bit per register.
  - Issue sets busy[in_issue_addr].
  - Any enabled write port clears busy[in_wr_addr].
  - Same-cycle issue and write to the same address: busy ends set, because the new producer takes precedence.
  - in_flush clears every busy bit and overrides issues in the same cycle. Writes still update data.
  - With ZERO_REG=1, issue to address 0 is ignored.
- out_rd_busy[p] = busy[rd_addr[p]] as registered. With BYPASS=1, it reads 0 when a write to that address occurs this cycle and no issue to it occurred in the previous cycle.
- out_waw_err: set when in_issue_en targets a register whose registered busy bit is 1 and no write clears it that cycle. It stays set until reset. The issue still proceeds.

## Timing
- Read latency 0 (combinational from address and, with bypass, from write inputs).
- Write and busy updates become visible in stored state after 1 rising edge.
- Asserting in_Rst_N mid-operation clears everything immediately. In-flight writes in that cycle are lost.
- No internal pipeline. The critical path is address decode plus bypass mux, NUM_WRITE deep.

## Structure
- Package regfile_pkg holds the default widths, the XLEN/FLEN constants, and the port-packing helper functions (slice index for port p).
- Sub-module regfile_scoreboard holds the busy-bit array, issue/write/flush priority, and out_waw_err. The data array and bypass muxes stay in regfile_mp.
- Integer instance: ZERO_REG=1, NUM_READ=2. FP instance: ZERO_REG=0, NUM_READ=3.

## Test plan
- Reset, then read all 32 addresses → all 0, busy 0. Assert reset mid-stream after writing x5=0xDEAD → next read x5=0.
- ZERO_REG=1: write addr 0 = 0xFFFF_FFFF_FFFF_FFFF → reads 0, bypass returns 0, issue to 0 leaves busy 0. Same with ZERO_REG=0 → reads back 0xFFFF_FFFF_FFFF_FFFF.
- Both write ports target x7 with 0x11 (port 0) and 0x22 (port 1) → bypass read = 0x22 same cycle; stored x7 = 0x22 next cycle. BYPASS=0 → same-cycle read returns old value.
- Issue x9, check busy=1 next cycle; write x9=0x5 → busy=0. Simultaneous issue and write of x9 → busy stays 1.
- Issue x3 twice without a write → out_waw_err=1 and sticky. Issue x3, write x3, issue x3 in the same cycle as the write → no error.
- Set busy on x1, x2, x31, then in_flush together with issue x4 → all busy 0, including x4. A write in the flush cycle is still stored.
